fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: queue entries, power of two, at least 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 address_imem  output  32  instruction word address to ROM; ROM uses bits [11:0].
REQ-006 q_imem  input  32  ROM read data, valid the cycle after its address is presented.
REQ-007 redirect_valid  input  1  branch/jump redirect pulse from the processor.
REQ-008 redirect_pc  input  32  new fetch address, sampled when redirect_valid=1.
REQ-009 out_valid  output  1  head entry valid.
REQ-010 out_ready  input  1  processor accepts the head entry.
REQ-011 out_inst  output  32  head instruction.
REQ-012 out_pc  output  32  word address of the head instruction.

Function
REQ-013 address_imem SHALL be driven directly from the fetch_pc register, with no combinational path from any input.
REQ-014 A request fires in a cycle when count + inflight < DEPTH and redirect_valid=0; fetch_pc then increments by 1 (word addressing, 32-bit wrap from FFFF_FFFF to 0).
REQ-015 When no request fires, fetch_pc and address_imem SHALL hold.
REQ-016 inflight is a 1-bit flag set by a fired request; the cycle after a request fires, q_imem and the issuing pc SHALL be enqueued, unless a kill applies (REQ-019).
REQ-017 Queue is FIFO; out_valid = (count != 0); out_inst/out_pc reflect the head entry.
REQ-018 Dequeue occurs when out_valid & out_ready; enqueue and dequeue in the same cycle leave count unchanged; the credit rule in REQ-014 guarantees no overflow.
REQ-019 Redirect (redirect_valid=1): next edge SHALL empty the queue (count=0, pointers reset), kill any in-flight response arriving that edge or the next, and load fetch_pc=redirect_pc; no request fires in the redirect cycle.
REQ-020 A handshake in the same cycle as a redirect counts as consumed by the processor; the queue is still cleared.
REQ-021 Back-to-back redirects: the last one wins; no instruction from an earlier target is ever enqueued.
REQ-022 Steady-state throughput SHALL be one instruction per cycle when out_ready is held at 1; first out_valid comes 2 cycles after reset release or redirect.
REQ-023 out_valid held with out_ready=0 SHALL keep out_inst/out_pc stable.

Reset
REQ-024 While reset=0: fetch_pc=RESET_PC, count=0, pointers=0, inflight=0, out_valid=0, out_inst=0, out_pc=0.
REQ-025 Reset asserted mid-operation SHALL clear all state immediately, without waiting for a clock edge; the response that was in flight is discarded.
REQ-026 The first request SHALL fire in the first cycle after reset deasserts.

Structure
REQ-027 XLEN (32), RESET_PC default, DEPTH default and the NOP encoding (32'h0) belong in the shared processor package/header.
REQ-028 Storage SHALL be one sub-module, fq_fifo: a DEPTH x 64-bit {pc, inst} circular buffer with count and a synchronous clear.
REQ-029 fetch_queue holds the fetch_pc register, the inflight/kill logic and the credit logic only.

Verification
REQ-030 Reset release, ROM preloaded mem[i]=i+32'h100, out_ready=1 -> out_pc 0,1,2,... with out_inst 100,101,102,... one per cycle; first out_valid 2 cycles after release.
REQ-031 out_ready=0 for 10 cycles -> exactly 4 entries (pc 0..3) held; address_imem frozen at 4; on releasing out_ready, order preserved with no duplicates.
REQ-032 Redirect to 32'h40 while full and with a request in flight -> the next out_valid shows pc 40 (inst mem[40h]); no stale pc appears.
REQ-033 Redirects to 10h then 20h on consecutive cycles -> the first delivered pc is 20h.
REQ-034 Asynchronous reset pulse mid-stream, between clock edges -> out_valid drops at once; restart at RESET_PC.
REQ-035 Random out_ready and random redirects for 10k cycles, against a scoreboard model -> delivered pc sequence always contiguous from the last redirect target, and inst == mem[pc].

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared processor definitions used by the instruction fetch queue.
// Holds the datapath width, reset defaults, NOP encoding and the queue entry layout.
package fetch_queue_pkg;

  localparam int XLEN             = 32;
  localparam int FQ_DEPTH_DEFAULT = 4;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam word_t NOP              = 32'h0000_0000;

  // One queue entry: the word address of the instruction and the instruction itself.
  typedef struct packed {
    word_t pc;
    word_t inst;
  } fq_entry_t;

  localparam fq_entry_t IDLE_ENTRY = '{pc: '0, inst: NOP};

  // Word-addressed sequential fetch; wraps naturally at 2^XLEN.
  function automatic word_t pc_incr(input word_t pc);
    return pc + word_t'(1);
  endfunction

endpackage

// File: rtl/fq_fifo.sv
// Circular buffer of {pc, inst} entries with occupancy count and synchronous clear.
// The head entry is presented combinationally; an empty buffer presents IDLE_ENTRY.
module fq_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   enq,
  input  fq_entry_t              enq_entry,
  input  logic                   deq,
  output fq_entry_t              head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  fq_entry_t mem [DEPTH];
  ptr_t      wr_ptr_reg;
  ptr_t      rd_ptr_reg;
  cnt_t      count_reg;
  logic      do_deq;

  assign valid  = (count_reg != '0);
  assign do_deq = deq && valid;
  assign count  = count_reg;
  assign head   = valid ? mem[rd_ptr_reg] : IDLE_ENTRY;

  // Storage needs no reset: the head is masked whenever the buffer is empty.
  always_ff @(posedge clock) begin
    if (enq && !clear) begin
      mem[wr_ptr_reg] <= enq_entry;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq) begin
        wr_ptr_reg <= wr_ptr_reg + ptr_t'(1);
      end
      if (do_deq) begin
        rd_ptr_reg <= rd_ptr_reg + ptr_t'(1);
      end
      case ({enq, do_deq})
        2'b10:   count_reg <= count_reg + cnt_t'(1);
        2'b01:   count_reg <= count_reg - cnt_t'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: drives a registered-read ROM and buffers responses in fq_fifo.
// Credits (queued + in-flight) throttle requests so the buffer can never overflow.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int    DEPTH    = FQ_DEPTH_DEFAULT,
  parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] address_imem,
  input  logic [XLEN-1:0] q_imem,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  word_t         fetch_pc_reg;
  word_t         issue_pc_reg;
  logic          inflight_reg;
  logic          kill_reg;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic          fire;
  logic          enq;
  logic          deq;
  fq_entry_t     enq_entry;
  fq_entry_t     head;

  assign address_imem = fetch_pc_reg;

  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight_reg};
  assign fire        = (credit_used < (CW+1)'(DEPTH)) && !redirect_valid;

  // A response landing on the redirect edge, or the edge after it, belongs to the old stream.
  assign enq       = inflight_reg && !redirect_valid && !kill_reg;
  assign enq_entry = '{pc: issue_pc_reg, inst: q_imem};
  assign deq       = out_valid && out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_reg <= RESET_PC;
      issue_pc_reg <= '0;
      inflight_reg <= 1'b0;
      kill_reg     <= 1'b0;
    end else begin
      inflight_reg <= fire;
      kill_reg     <= redirect_valid;
      if (redirect_valid) begin
        fetch_pc_reg <= redirect_pc;
      end else if (fire) begin
        fetch_pc_reg <= pc_incr(fetch_pc_reg);
        issue_pc_reg <= fetch_pc_reg;
      end
    end
  end

  fq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (redirect_valid),
    .enq       (enq),
    .enq_entry (enq_entry),
    .deq       (deq),
    .head      (head),
    .valid     (out_valid),
    .count     (count)
  );

  assign out_pc   = head.pc;
  assign out_inst = head.inst;

endmodule
